video_line_buffer: RTL and testbench

- Double-banked pixel line buffer directly downstream of the video timing generator.
- Consumes hc/vc/hbl from the timing block and displays the current line from one bank while a line renderer fills the other bank with the next line.
- Banks swap at the start of each horizontal blank.
- Issues a one-cycle line request per line, carrying the line number to render next.

---
 rtl/video_line_buffer.sv | 150 +++++++++++++++
 tb/tb_video_line_buffer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_line_buffer.sv
// rtl/video_line_buffer.sv - double-banked display line buffer fed by a line renderer
// Optional VLB_UNDERRUN_MASK_EN: per-bank fill length blanks pixels the renderer never wrote.
module video_line_buffer #(
    parameter int PIX_W  = 12,
    parameter int LINE_W = 320,
    parameter int ADDR_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [8:0]       hc,
    input  logic [8:0]       vc,
    input  logic             hbl,
    input  logic [8:0]       vtotal,
    output logic             line_req,
    output logic [8:0]       req_line,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [PIX_W-1:0] wr_data,
    output logic [PIX_W-1:0] pix_out,
    output logic             underrun,
    output logic [7:0]       underrun_cnt
);
    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(LINE_W - 1);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [9:0]      LINE_LIM = 10'(LINE_W);

    logic [PIX_W-1:0] mem_q [2][DEPTH];

    state_t           state_q, state_d;
    logic [ADDR_W:0]  wptr_q, wptr_d;
    logic             disp_bank_q, disp_bank_d;
    logic             hbl_q;
    logic             wr_ready_q;
    logic             line_req_q;
    logic [8:0]       req_line_q, req_line_d;
    logic             underrun_q, underrun_d;
    logic [7:0]       underrun_cnt_q, underrun_cnt_d;
    logic [PIX_W-1:0] pix_out_q, pix_out_d;
    logic             swap, wr_fire, last_wr, show;
    logic [ADDR_W-1:0] rd_addr;

    assign swap    = hbl && !hbl_q;
    assign wr_fire = wr_valid && wr_ready_q;
    assign last_wr = wr_fire && (wptr_q == LAST_PTR);
    assign rd_addr = ADDR_W'(hc);

`ifdef VLB_UNDERRUN_MASK_EN
    // Fill length the bank reached when it was handed over to display.
    logic [ADDR_W:0] fill_len_q [2];

    always_ff @(posedge clk) begin
        if (!reset) begin
            fill_len_q[0] <= '0;
            fill_len_q[1] <= '0;
        end else if (swap) begin
            fill_len_q[~disp_bank_q] <= wptr_q + {{ADDR_W{1'b0}}, wr_fire};
        end
    end

    assign show = !hbl_q && ({1'b0, hc} < LINE_LIM)
                  && ((ADDR_W+1)'(hc) < fill_len_q[disp_bank_q]);
`else
    assign show = !hbl_q && ({1'b0, hc} < LINE_LIM);
`endif

    // Writes always target the bank not on display, so no read/write collision.
    always_ff @(posedge clk) begin
        if (reset && wr_fire) begin
            mem_q[~disp_bank_q][wptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        wptr_d         = wptr_q;
        disp_bank_d    = disp_bank_q;
        req_line_d     = req_line_q;
        underrun_d     = 1'b0;
        underrun_cnt_d = underrun_cnt_q;
        pix_out_d      = show ? mem_q[disp_bank_q][rd_addr] : '0;

        case (state_q)
            ST_FILL: begin
                if (wr_fire) begin
                    wptr_d = wptr_q + PTR_ONE;
                    if (last_wr) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: ;
        endcase

        // A write landing on the swap edge still completes the outgoing fill.
        if (swap) begin
            disp_bank_d = ~disp_bank_q;
            wptr_d      = '0;
            state_d     = ST_FILL;
            req_line_d  = (vc == vtotal) ? 9'd0 : vc + 9'd1;
            if (state_q == ST_FILL && !last_wr) begin
                underrun_d = 1'b1;
                if (underrun_cnt_q != 8'hFF) begin
                    underrun_cnt_d = underrun_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hbl_q          <= 1'b0;
            disp_bank_q    <= 1'b0;
            wptr_q         <= '0;
            wr_ready_q     <= 1'b0;
            line_req_q     <= 1'b0;
            req_line_q     <= '0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
            pix_out_q      <= '0;
        end else begin
            hbl_q          <= hbl;
            disp_bank_q    <= disp_bank_d;
            wptr_q         <= wptr_d;
            wr_ready_q     <= (state_d == ST_FILL);
            line_req_q     <= swap;
            req_line_q     <= req_line_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
            pix_out_q      <= pix_out_d;
        end
    end

    assign wr_ready     = wr_ready_q;
    assign line_req     = line_req_q;
    assign req_line     = req_line_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;
    assign pix_out      = pix_out_q;
endmodule

// File: tb/tb_video_line_buffer.sv
// tb/tb_video_line_buffer.sv - scoreboard bench for video_line_buffer
module tb_video_line_buffer;
    localparam int PIX_W  = 12;
    localparam int LINE_W = 320;
    localparam int ADDR_W = 9;

    logic             clk = 1'b0;
    logic             reset;
    logic [8:0]       hc, vc, vtotal;
    logic             hbl;
    logic             wr_valid;
    logic [PIX_W-1:0] wr_data;
    logic             line_req, wr_ready, underrun;
    logic [8:0]       req_line;
    logic [PIX_W-1:0] pix_out;
    logic [7:0]       underrun_cnt;

    always #5 clk = ~clk;

    video_line_buffer #(.PIX_W(PIX_W), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .hc(hc), .vc(vc), .hbl(hbl), .vtotal(vtotal),
        .line_req(line_req), .req_line(req_line), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_data(wr_data), .pix_out(pix_out),
        .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [PIX_W-1:0] m_bank [2][512];
    bit               m_known [2][512];
    int               m_flen [2];
    bit               m_disp, m_ready, m_hbl_q, m_line_req, m_underrun;
    int               m_state, m_wptr;
    logic [8:0]       m_req_line;
    logic [7:0]       m_ucnt;

    typedef struct {
        logic [PIX_W-1:0] pix;
        bit               pix_known;
        bit               ready;
        bit               lreq;
        logic [8:0]       rline;
        bit               ur;
        logic [7:0]       ucnt;
    } exp_t;
    exp_t sb[$];

    // Renderer stimulus state
    int r_limit = 0, r_dly = 0, r_base = 0;
    bit r_toggle = 0, tog = 0;
    int rd_count = 0, since_swap = 0;

    // Per-period observations
    int lreq_cnt, ur_cnt, ready_hi, acc_cnt;
    bit count_acc;
    logic [8:0] last_req;
    logic [PIX_W-1:0] cap [LINE_W];

    task automatic cycle();
        exp_t e;
        bit swap, fire, show;
        int hci;
        hci = int'(hc);
        swap = 0;
        fire = 0;
        if (!reset) begin
            e.pix = '0; e.pix_known = 1;
            m_disp = 0; m_state = 0; m_wptr = 0; m_ready = 0; m_hbl_q = 0;
            m_line_req = 0; m_req_line = '0; m_underrun = 0; m_ucnt = '0;
            m_flen[0] = 0; m_flen[1] = 0;
        end else begin
            swap = hbl && !m_hbl_q;
            fire = wr_valid && m_ready;
            show = !m_hbl_q && hci < LINE_W;
`ifdef VLB_UNDERRUN_MASK_EN
            show = show && hci < m_flen[m_disp];
`endif
            e.pix_known = show ? m_known[m_disp][hci] : 1'b1;
            e.pix = show ? m_bank[m_disp][hci] : '0;
            if (fire) begin
                m_bank[!m_disp][m_wptr] = wr_data;
                m_known[!m_disp][m_wptr] = 1;
            end
            m_line_req = 0;
            m_underrun = 0;
            if (swap) begin
                if (m_state == 1 && !(fire && m_wptr == LINE_W-1)) begin
                    m_underrun = 1;
                    if (m_ucnt != 8'hFF) m_ucnt = m_ucnt + 8'd1;
                end
                m_flen[!m_disp] = m_wptr + (fire ? 1 : 0);
                m_disp = !m_disp;
                m_wptr = 0;
                m_state = 1;
                m_line_req = 1;
                m_req_line = (vc == vtotal) ? 9'd0 : vc + 9'd1;
            end else if (fire) begin
                if (m_wptr == LINE_W-1) m_state = 2;
                m_wptr++;
            end
            m_ready = (m_state == 1);
            m_hbl_q = hbl;
        end
        e.ready = m_ready; e.lreq = m_line_req; e.rline = m_req_line;
        e.ur = m_underrun; e.ucnt = m_ucnt;
        sb.push_back(e);

        if (count_acc && wr_valid && wr_ready === 1'b1) acc_cnt++;
        if (fire) rd_count++;
        if (swap) begin
            rd_count = 0;
            since_swap = 0;
        end else begin
            since_swap++;
        end
        tog = !tog;

        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.pix_known) begin
            checks++;
            if (pix_out !== e.pix) begin
                failures++;
                $display("FAIL pix_out hc=%0d got=%0d exp=%0d", hci, pix_out, e.pix);
            end
        end
        checks++;
        if (wr_ready !== e.ready) begin
            failures++;
            $display("FAIL wr_ready hc=%0d got=%b exp=%b", hci, wr_ready, e.ready);
        end
        checks++;
        if (line_req !== e.lreq) begin
            failures++;
            $display("FAIL line_req hc=%0d got=%b exp=%b", hci, line_req, e.lreq);
        end
        checks++;
        if (req_line !== e.rline) begin
            failures++;
            $display("FAIL req_line got=%0d exp=%0d", req_line, e.rline);
        end
        checks++;
        if (underrun !== e.ur || underrun_cnt !== e.ucnt) begin
            failures++;
            $display("FAIL underrun got=%b/%0d exp=%b/%0d", underrun, underrun_cnt, e.ur, e.ucnt);
        end
        if (line_req === 1'b1) begin
            lreq_cnt++;
            last_req = req_line;
        end
        if (underrun === 1'b1) ur_cnt++;
        if (wr_ready === 1'b1) ready_hi++;
        if (hci < LINE_W) cap[hci] = pix_out;
    endtask

    // One line period starting at the hbl rise; extra stretches the blank.
    task automatic run_period(input int vc_v, input int extra, input int lim,
                              input int dly, input bit tgl, input int base);
        int nblank;
        nblank = 15 + extra;
        vc = 9'(vc_v);
        lreq_cnt = 0; ur_cnt = 0; ready_hi = 0; acc_cnt = 0; count_acc = 0;
        for (int i = 0; i < 336 + extra; i++) begin
            if (i < nblank) begin
                hbl = 1;
                hc = 9'((i < 15) ? 320 + i : 334);
            end else if (i == nblank) begin
                hbl = 0;
                hc = 9'd335;
            end else begin
                hbl = 0;
                hc = 9'(i - nblank - 1);
            end
            if (i == 1) begin
                r_limit = lim; r_dly = dly; r_toggle = tgl; r_base = base;
                count_acc = 1;
            end
            wr_valid = (rd_count < r_limit) && (since_swap >= r_dly) && (!r_toggle || tog);
            wr_data = PIX_W'(r_base + rd_count);
            cycle();
        end
    endtask

    task automatic test_reset();
        reset = 0; wr_valid = 0; wr_data = '0; vc = '0; vtotal = 9'd261;
        lreq_cnt = 0; ur_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            hbl = (i % 2 == 1);
            hc = 9'(i);
            cycle();
            checks++;
            if (pix_out !== '0 || wr_ready !== 1'b0 || line_req !== 1'b0 || underrun_cnt !== 8'd0) begin
                failures++;
                $display("FAIL reset_outputs got pix=%0d rdy=%b lreq=%b ucnt=%0d exp all 0",
                         pix_out, wr_ready, line_req, underrun_cnt);
            end
        end
        reset = 1; hbl = 0;
        for (int i = 0; i < 4; i++) begin
            hc = 9'(i);
            cycle();
        end
        checks++;
        if (lreq_cnt != 0) begin
            failures++;
            $display("FAIL reset_no_swap got=%0d requests exp=0", lreq_cnt);
        end
    endtask

    task automatic test_normal_line();
        run_period(100, 0, 320, 0, 0, 1);
        checks++;
        if (lreq_cnt != 1 || last_req !== 9'd101) begin
            failures++;
            $display("FAIL normal_req got=%0d/%0d exp=1/101", lreq_cnt, last_req);
        end
        checks++;
        if (ready_hi != 320) begin
            failures++;
            $display("FAIL normal_ready_cycles got=%0d exp=320", ready_hi);
        end
        run_period(101, 0, 320, 0, 0, 500);
        for (int k = 0; k < LINE_W; k++) begin
            checks++;
            if (cap[k] !== PIX_W'(k + 1)) begin
                failures++;
                $display("FAIL normal_pix hc=%0d got=%0d exp=%0d", k, cap[k], k + 1);
            end
        end
    endtask

    task automatic test_wrap();
        run_period(261, 0, 320, 0, 0, 1000);
        checks++;
        if (last_req !== 9'd0) begin
            failures++;
            $display("FAIL wrap_req_last got=%0d exp=0", last_req);
        end
        run_period(0, 0, 320, 0, 0, 1500);
        checks++;
        if (last_req !== 9'd1) begin
            failures++;
            $display("FAIL wrap_req_first got=%0d exp=1", last_req);
        end
    endtask

    task automatic test_underrun();
        int expv;
        run_period(1, 0, 200, 0, 0, 2000);
        run_period(2, 0, 320, 0, 0, 2500);
        checks++;
        if (ur_cnt != 1 || underrun_cnt !== 8'd1) begin
            failures++;
            $display("FAIL underrun_pulse got=%0d/%0d exp=1/1", ur_cnt, underrun_cnt);
        end
        for (int k = 0; k < LINE_W; k++) begin
`ifdef VLB_UNDERRUN_MASK_EN
            expv = (k < 200) ? 2000 + k : 0;
`else
            expv = (k < 200) ? 2000 + k : 1000 + k;
`endif
            checks++;
            if (cap[k] !== PIX_W'(expv)) begin
                failures++;
                $display("FAIL underrun_pix hc=%0d got=%0d exp=%0d", k, cap[k], expv);
            end
        end
    endtask

    task automatic test_simultaneous();
        run_period(3, 0, 320, 16, 0, 3000);
        checks++;
        if (acc_cnt != 319) begin
            failures++;
            $display("FAIL simul_pre_writes got=%0d exp=319", acc_cnt);
        end
        run_period(4, 320, 320, 0, 1, 3500);
        checks++;
        if (ur_cnt != 0 || underrun_cnt !== 8'd1) begin
            failures++;
            $display("FAIL simul_no_underrun got=%0d/%0d exp=0/1", ur_cnt, underrun_cnt);
        end
        checks++;
        if (cap[319] !== PIX_W'(3319) || cap[0] !== PIX_W'(3000)) begin
            failures++;
            $display("FAIL simul_pix got=%0d,%0d exp=3000,3319", cap[0], cap[319]);
        end
    endtask

    task automatic test_back_to_back();
        checks++;
        if (acc_cnt != 320) begin
            failures++;
            $display("FAIL backpressure_writes got=%0d exp=320", acc_cnt);
        end
        run_period(5, 0, 0, 0, 0, 0);
        checks++;
        if (ur_cnt != 0) begin
            failures++;
            $display("FAIL backpressure_underrun got=%0d exp=0", ur_cnt);
        end
        for (int k = 0; k < LINE_W; k++) begin
            checks++;
            if (cap[k] !== PIX_W'(3500 + k)) begin
                failures++;
                $display("FAIL backpressure_pix hc=%0d got=%0d exp=%0d", k, cap[k], 3500 + k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_line();
        test_wrap();
        test_underrun();
        test_simultaneous();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
